// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial add/subtract engine: FSM state
// encoding and operation codes.
package serial_addsub_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_bit_cell.sv
// One-bit full adder / full subtractor shared by every bit position of the
// serial engine; cin/cout carry the carry (add) or the borrow (sub).
module addsub_bit_cell
    import serial_addsub_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic op,
    output logic s,
    output logic cout
);

    // Sum/difference bit and carry/borrow out for the selected operation
    always_comb begin
        s    = 1'b0;
        cout = 1'b0;
        if (op == OP_SUB) begin
            s    = a ^ b ^ cin;
            cout = (~a & b) | (~(a ^ b) & cin);
        end else begin
            s    = a ^ b ^ cin;
            cout = (a & b) | (cin & (a ^ b));
        end
    end

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract engine: operands are shifted LSB-first through one
// shared cell over WIDTH clocks; start/busy/done handshake to the requester.
module serial_addsub_ctrl
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_borrow
);

    localparam int CW = $clog2(WIDTH);

    logic [1:0]       state_r;
    logic [1:0]       next_state_s;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] opa_r;
    logic [WIDTH-1:0] opb_r;
    logic [WIDTH-1:0] acc_r;
    logic             op_r;
    logic             carry_r;
    logic             sum_s;
    logic             cout_s;
    logic             last_s;
    logic             busy_nxt_s;
    logic             done_nxt_s;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] result_r;
    logic             cb_r;

    // Counter stops at WIDTH-1 so it never wraps, even for power-of-two WIDTH
    assign last_s = (cnt_r == CW'(WIDTH - 1));

    addsub_bit_cell u_cell (
        .a    (opa_r[0]),
        .b    (opb_r[0]),
        .cin  (carry_r),
        .op   (op_r),
        .s    (sum_s),
        .cout (cout_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    next_state_s = S_RUN;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (last_s) begin
                    next_state_s = S_DONE;
                end else begin
                    next_state_s = S_RUN;
                end
            end
            S_DONE:  next_state_s = S_IDLE;
            default: next_state_s = S_IDLE;
        endcase
    end

    // FSM output decode, computed one state ahead so the flags are registered
    always_comb begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
        case (next_state_s)
            S_RUN:   busy_nxt_s = 1'b1;
            S_DONE:  done_nxt_s = 1'b1;
            default: begin
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b0;
            end
        endcase
    end

    // Registered handshake flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
        end
    end

    // Operand/accumulator shifting, carry recirculation and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= {CW{1'b0}};
            opa_r    <= {WIDTH{1'b0}};
            opb_r    <= {WIDTH{1'b0}};
            acc_r    <= {WIDTH{1'b0}};
            op_r     <= 1'b0;
            carry_r  <= 1'b0;
            result_r <= {WIDTH{1'b0}};
            cb_r     <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        opa_r   <= a;
                        opb_r   <= b;
                        op_r    <= op;
                        carry_r <= 1'b0;
                        cnt_r   <= {CW{1'b0}};
                    end
                end
                S_RUN: begin
                    carry_r <= cout_s;
                    opa_r   <= {1'b0, opa_r[WIDTH-1:1]};
                    opb_r   <= {1'b0, opb_r[WIDTH-1:1]};
                    acc_r   <= {sum_s, acc_r[WIDTH-1:1]};
                    if (last_s) begin
                        result_r <= {sum_s, acc_r[WIDTH-1:1]};
                        cb_r     <= cout_s;
                    end else begin
                        cnt_r <= cnt_r + CW'(1'b1);
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign busy         = busy_r;
    assign done         = done_r;
    assign result       = result_r;
    assign carry_borrow = cb_r;

endmodule
